ysyx_22040759_gpr_sb: RTL
=========================

Name: ysyx_22040759_gpr_sb

Overview:
Parametrised multi-port general-purpose register file with an integrated write-pending scoreboard and optional write-to-read bypass. It serves decode (operand read plus hazard check) and writeback (results from one or more pipes) in the dual-issue core. It replaces the fixed 2R1W, no-bypass GPR.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of 2, >=2); AW = clog2(NREG)
NRD, 2, number of read ports
NWR, 2, number of write ports
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
raddr  in  NRD*AW  read addresses; port p = bits [p*AW +: AW]
rdata  out  NRD*XLEN  read data, combinational
rbusy  out  NRD  port p operand not yet available (RAW stall)
wen  in  NWR  write enables
waddr  in  NWR*AW  write addresses
wdata  in  NWR*XLEN  write data
issue_en  in  1  decode issues an instruction that will write issue_rd
issue_rd  in  AW  destination register of the issuing instruction
issue_waw  out  1  issue_rd already pending; the issue is refused
nbusy  out  AW+1  count of currently pending registers

Behaviour:
- Reset (rst=1 at posedge): all registers <= 0, all busy bits <= 0. Writes and issues in that cycle are ignored. nbusy reads 0 the next cycle. Reset mid-operation discards all pending state.
- Write:
  - Port w writes wdata[w] to waddr[w] at posedge when wen[w].
  - Collision between write ports: the highest-index port wins.
  - With ZERO_REG, writes to reg 0 are dropped.
- Read is combinational: rdata[p] = 0 if ZERO_REG && raddr[p]==0. Otherwise:
  - BYPASS=1 and any wen[w] && waddr[w]==raddr[p] (w != reg0 case): wdata of the highest such w.
  - Otherwise the array value.
- Scoreboard, one busy bit per register:
  - Set: issue_en && !issue_waw && !(ZERO_REG && issue_rd==0) sets busy[issue_rd] at posedge.
  - Clear: any wen[w] clears busy[waddr[w]] at posedge.
  - Simultaneous set and clear on the same register: set wins (the new writer is pending).
  - issue_waw = issue_en && busy[issue_rd]. It is combinational and considers busy state before this cycle's clears. A refused issue changes nothing; decode must stall and retry.
- rbusy[p]:
  - BYPASS=1: busy[raddr[p]] && no same-cycle write matches raddr[p].
  - BYPASS=0: busy[raddr[p]], regardless of writes this cycle.
  - Always 0 for reg 0 when ZERO_REG.
- A write to a register that is not busy is legal (e.g. CSR/untracked path): data is updated, busy is unchanged.
- nbusy is the registered population count of the busy bits. It updates the cycle after set/clear and never exceeds NREG.
- Latency: write-to-read through the array is 1 cycle. Through bypass it is 0 cycles.

Decomposition:
- Shared package/define file: XLEN default, NREG default, the AW derivation macro, and the zero-register index constant.
- Sub-module ysyx_22040759_scoreboard holds busy[NREG], the set/clear priority logic, issue_waw, nbusy, and per-port rbusy base lookup.
- The top level holds the data array, the write-collision priority, and the bypass muxes.

Test Plan:
- Reset: write x5=0xDEADBEEF, then assert rst for 1 cycle -> raddr=5 reads 0; rbusy=0; nbusy=0.
- Bypass: wen[0]=1, waddr[0]=7, wdata[0]=0x1234 with raddr[0]=7 in the same cycle -> BYPASS=1: rdata=0x1234. BYPASS=0: old value this cycle, 0x1234 the next cycle.
- Write collision: wen=2'b11, both waddr=3, wdata0=0xAAAA, wdata1=0xBBBB -> x3 reads 0xBBBB.
- Scoreboard RAW:
  - Issue rd=9 -> next cycle rbusy=1 for raddr=9 and nbusy=1.
  - Write x9=0x55 -> same cycle rbusy=0 and rdata=0x55 (BYPASS=1).
  - Next cycle nbusy=0.
- WAW and simultaneous events:
  - issue_rd=9 while x9 busy -> issue_waw=1; nbusy unchanged.
  - Issue rd=4 in the same cycle as a writeback to x4 while x4 is not busy -> busy[4]=1 afterwards.
- Zero register: write x0=0xFFFF and issue rd=0 -> x0 reads 0; issue_waw=0; nbusy stays 0.

Source files
------------

// File: rtl/ysyx_22040759_gpr_sb_pkg.sv
// Shared definitions for the multi-port GPR file and its write-pending scoreboard.
// Contents:
//   XLEN_DEFAULT / NREG_DEFAULT : default data width and register count
//   ZERO_IDX                    : index of the hardwired-zero register
//   addr_width()                : register address width derived from the register count
package ysyx_22040759_gpr_sb_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int ZERO_IDX     = 0;

  // Register counts are powers of two, so clog2 gives an exact index width.
  // A floor of 1 keeps the address ports legal for degenerate sizes.
  function automatic int addr_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/ysyx_22040759_scoreboard.sv
// Write-pending scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   raddr           : NRD packed read addresses, used for the busy lookup
//   wen, waddr      : NWR writeback ports; each write clears its register's busy bit
//   issue_en/rd     : decode issue request that marks issue_rd pending
//   issue_waw       : issue_rd is already pending, so the issue is refused
//   rbusy_base      : raw busy bit for each read port, before bypass masking
//   nbusy           : registered count of pending registers
module ysyx_22040759_scoreboard
  import ysyx_22040759_gpr_sb_pkg::*;
#(
  parameter int NREG     = NREG_DEFAULT,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_waw,
  output logic [NRD-1:0]      rbusy_base,
  output logic [AW:0]         nbusy
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     nbusy_q, nbusy_d;
  logic            set_ok;

  // The hazard check looks at the busy state before this cycle's clears,
  // so a writer retiring in the same cycle does not unblock the issue.
  assign issue_waw = issue_en && busy_q[issue_rd];
  assign set_ok    = issue_en && !issue_waw &&
                     !((ZERO_REG != 0) && (issue_rd == AW'(ZERO_IDX)));

  // Clears are applied first and the set last, so a new writer issued in the
  // same cycle as a retiring write to the same register stays pending.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (wen[w]) busy_d[waddr[w*AW +: AW]] = 1'b0;
    end
    if (set_ok) busy_d[issue_rd] = 1'b1;
    if (rst) busy_d = '0;
  end

  // Counting the next-state bits makes nbusy line up with the busy bits it describes.
  always_comb begin
    nbusy_d = '0;
    for (int i = 0; i < NREG; i++) begin
      nbusy_d = nbusy_d + (AW+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    busy_q  <= busy_d;
    nbusy_q <= nbusy_d;
  end

  always_comb begin
    rbusy_base = '0;
    for (int p = 0; p < NRD; p++) begin
      rbusy_base[p] = busy_q[raddr[p*AW +: AW]];
    end
  end

  assign nbusy = nbusy_q;

endmodule

// File: rtl/ysyx_22040759_gpr_sb.sv
// Multi-port general-purpose register file with an integrated write-pending
// scoreboard and optional same-cycle writeback bypass.
// Ports:
//   clk, rst        : clock and synchronous active-high reset (clears data and busy state)
//   raddr / rdata   : NRD combinational read ports (packed, port p at [p*W +: W])
//   rbusy           : per read port, the operand is still pending (RAW stall)
//   wen/waddr/wdata : NWR writeback ports; the highest-index port wins on collision
//   issue_en/rd     : decode marks issue_rd as pending
//   issue_waw       : issue_rd already pending; the issue is refused
//   nbusy           : registered count of pending registers
module ysyx_22040759_gpr_sb
  import ysyx_22040759_gpr_sb_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREG     = NREG_DEFAULT,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_waw,
  output logic [AW:0]         nbusy
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NRD-1:0]  rbusy_base;
  logic [NRD-1:0]  wr_hit;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   wr_idx;

  ysyx_22040759_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .raddr      (raddr),
    .wen        (wen),
    .waddr      (waddr),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .issue_waw  (issue_waw),
    .rbusy_base (rbusy_base),
    .nbusy      (nbusy)
  );

  // Ports are applied in ascending order so the highest-index port wins a collision.
  always_comb begin
    wr_idx = '0;
    for (int r = 0; r < NREG; r++) regs_d[r] = regs_q[r];
    for (int w = 0; w < NWR; w++) begin
      wr_idx = waddr[w*AW +: AW];
      if (wen[w] && !((ZERO_REG != 0) && (wr_idx == AW'(ZERO_IDX)))) begin
        regs_d[wr_idx] = wdata[w*XLEN +: XLEN];
      end
    end
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs_d[r] = '0;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Read mux: array value, overridden by the highest matching writeback when
  // bypass is enabled, and forced to zero for the hardwired register.
  // A write match also hides the busy bit because the operand is being
  // delivered this cycle.
  always_comb begin
    rdata  = '0;
    rbusy  = '0;
    wr_hit = '0;
    rd_idx = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_idx = raddr[p*AW +: AW];
      rdata[p*XLEN +: XLEN] = regs_q[rd_idx];
      if (BYPASS != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (wen[w] && (waddr[w*AW +: AW] == rd_idx)) begin
            wr_hit[p] = 1'b1;
            rdata[p*XLEN +: XLEN] = wdata[w*XLEN +: XLEN];
          end
        end
      end
      rbusy[p] = rbusy_base[p] && !wr_hit[p];
      if ((ZERO_REG != 0) && (rd_idx == AW'(ZERO_IDX))) begin
        rdata[p*XLEN +: XLEN] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

endmodule
